holy_pipe_stage: RTL and testbench
==================================

HOLY_PIPE_STAGE -- requirements
Module: holy_pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..512.
REQ-002 SHALL have parameter SKID, default 1: 1 selects a two-entry skid stage with registered in_ready; 0 selects a single-entry stage with combinational in_ready.
REQ-003 SHALL have parameter BUBBLE, type logic [WIDTH-1:0], default all-zero: value driven on out_data while the stage is empty.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: stage accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: upstream payload (typically a packed stage struct).
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes out_data this cycle.
REQ-011 SHALL have port out_data, output, WIDTH bits: head payload, or BUBBLE when empty.
REQ-012 SHALL have port flush, input, 1 bit: discard all held entries (branch/jump redirect).
REQ-013 SHALL have port occupancy, output, 2 bits: number of held entries, 0..2.

Function
REQ-014 SHALL transfer in on the edge where in_valid & in_ready & ~flush, and transfer out on the edge where out_valid & out_ready.
REQ-015 SHALL, with SKID=1, implement states EMPTY (0 entries), FULL (main only) and SKIDDED (main + skid).
REQ-016 SHALL take these transitions: EMPTY + in -> FULL; FULL + in, no out -> SKIDDED; FULL + out, no in -> EMPTY; FULL + in + out -> FULL, main loaded with in_data; SKIDDED + out -> FULL, main loaded from skid.
REQ-017 SHALL, with SKID=1, drive in_ready = 1 in EMPTY and FULL and 0 in SKIDDED; in_ready SHALL be a register output with no combinational path from out_ready.
REQ-018 SHALL, with SKID=0, use EMPTY and FULL only and drive in_ready = ~out_valid | out_ready, giving a full-throughput single stage.
REQ-019 SHALL have latency of exactly 1 cycle from accepted input to out_valid when the stage was empty.
REQ-020 SHALL sustain 1 transfer per cycle when out_ready is held at 1.
REQ-021 SHALL preserve order (FIFO) and never drop or duplicate an accepted entry, except under flush.
REQ-022 SHALL hold out_data stable while out_valid & ~out_ready.
REQ-023 SHALL make flush dominant: on a flush edge, state goes to EMPTY, a simultaneous input is discarded, and a simultaneous output handshake still counts as consumed downstream.
REQ-024 SHALL drive out_data = BUBBLE whenever out_valid = 0.
REQ-025 SHALL drive occupancy = 0 in EMPTY, 1 in FULL, and 2 in SKIDDED.
REQ-026 SHALL have in_ready and out_valid depend only on state, except in_ready in SKID=0 mode.

Reset
REQ-027 SHALL, while rst = 1, force state EMPTY, out_valid = 0, occupancy = 0, out_data = BUBBLE, in_ready = 0.
REQ-028 SHALL assert in_ready = 1 on the first clk edge after rst deasserts.
REQ-029 SHALL abandon held entries when rst asserts mid-operation, with no partial output.

Structure
REQ-030 SHALL place the state enum (PS_EMPTY, PS_FULL, PS_SKIDDED) in holy_core_pkg.
REQ-031 SHALL be instantiable with WIDTH = $bits(if_id_reg_t), $bits(id_exe_reg_t), etc., replacing ad-hoc stage registers.
REQ-032 SHALL contain no sub-modules; datapath is main_q, skid_q and the state register.

Verification
REQ-033 SHALL verify throughput: SKID=1, WIDTH=32, out_ready=1, inputs 0x1..0x8 back-to-back -> outputs 0x1..0x8 on consecutive cycles, first output one cycle after first input.
REQ-034 SHALL verify backpressure: accept 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA stable; then out_ready=1 -> 0xA, 0xB in order.
REQ-035 SHALL verify flush: occupancy=2 plus flush with in_valid=1, in_data=0xC -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE; 0xC is never output.
REQ-036 SHALL verify SKID=0 mode: out_ready toggling 1,0,1 with continuous input -> in_ready mirrors out_ready while full; no loss or duplication.
REQ-037 SHALL verify reset mid-operation: rst asserted asynchronously between edges with occupancy=1 -> out_valid=0 immediately, in_ready=1 after release.
REQ-038 SHALL verify random stimulus: 10,000 cycles of random in_valid, out_ready and flush against a FIFO scoreboard model, with zero mismatches.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared pipeline-stage definitions for the holy core: stage state encoding
// and small decode helpers used by the elastic stage registers.
package holy_core_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY   = 2'd0,
    PS_FULL    = 2'd1,
    PS_SKIDDED = 2'd2
  } ps_state_e;

  localparam logic [1:0] PS_OCC_NONE = 2'd0;
  localparam logic [1:0] PS_OCC_ONE  = 2'd1;
  localparam logic [1:0] PS_OCC_TWO  = 2'd2;

  function automatic logic [1:0] ps_occupancy(input ps_state_e s);
    case (s)
      PS_EMPTY:   return PS_OCC_NONE;
      PS_FULL:    return PS_OCC_ONE;
      PS_SKIDDED: return PS_OCC_TWO;
      default:    return PS_OCC_NONE;
    endcase
  endfunction

  // A stage presents data downstream whenever it holds at least one entry.
  function automatic logic ps_holds(input ps_state_e s);
    case (s)
      PS_EMPTY:   return 1'b0;
      PS_FULL:    return 1'b1;
      PS_SKIDDED: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic ps_accepts(input ps_state_e s);
    case (s)
      PS_EMPTY:   return 1'b1;
      PS_FULL:    return 1'b1;
      PS_SKIDDED: return 1'b0;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/holy_pipe_stage.sv
// Elastic valid/ready pipeline stage: optional two-entry skid buffer with a
// registered in_ready, flush-dominant redirect, and BUBBLE on empty output.
module holy_pipe_stage
  import holy_core_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      SKID   = 32'd1,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  ps_state_e        state_q;
  ps_state_e        state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [1:0]       occupancy_q;
  logic             in_fire_s;
  logic             out_fire_s;

  // in_ready_q is low through reset and the first cycle after it, so it also
  // gates the single-entry combinational ready.
  if (SKID != 32'd0) begin : g_skid
    assign in_ready = in_ready_q;
  end else begin : g_single
    assign in_ready = in_ready_q & (~out_valid_q | out_ready);
  end

  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;
  // main_q is parked at BUBBLE whenever the stage is empty.
  assign out_data  = main_q;

  // Handshake qualification; a flush cancels any incoming transfer.
  always_comb begin
    in_fire_s  = in_valid & in_ready & ~flush;
    out_fire_s = out_valid_q & out_ready;
  end

  // Next-state and datapath selection for the stage FSM.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire_s) begin
            state_d = PS_FULL;
            main_d  = in_data;
          end else begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (in_fire_s && out_fire_s) begin
            state_d = PS_FULL;
            main_d  = in_data;
          end else if (in_fire_s) begin
            state_d = PS_SKIDDED;
            skid_d  = in_data;
          end else if (out_fire_s) begin
            state_d = PS_EMPTY;
            main_d  = BUBBLE;
          end else begin
            state_d = PS_FULL;
          end
        end
        PS_SKIDDED: begin
          if (out_fire_s) begin
            state_d = PS_FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end else begin
            state_d = PS_SKIDDED;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State, payload and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      occupancy_q <= PS_OCC_NONE;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= ps_holds(state_d);
      in_ready_q  <= ps_accepts(state_d);
      occupancy_q <= ps_occupancy(state_d);
    end
  end

endmodule

// File: tb/tb_holy_pipe_stage.sv
// Bench for holy_pipe_stage: a SKID=1 instance with a non-zero BUBBLE and a
// SKID=0 instance, each tracked by a FIFO scoreboard sampled on the falling edge.
module tb_holy_pipe_stage;

  localparam logic [31:0] BUBBLE1 = 32'hDEAD_BEEF;
  localparam logic [31:0] BUBBLE0 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, flush1 = 1'b0;
  logic [31:0] in_data1 = 32'd0;
  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [1:0]  occupancy1;

  logic        in_valid0 = 1'b0, out_ready0 = 1'b0, flush0 = 1'b0;
  logic [31:0] in_data0 = 32'd0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;

  int errors = 0;
  int checks = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic        fresh = 1'b1;
  logic        hold1_prev = 1'b0;
  logic [31:0] data1_prev = 32'd0;

  always #5 clk = ~clk;

  holy_pipe_stage #(.WIDTH(32), .SKID(1), .BUBBLE(BUBBLE1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .flush(flush1), .occupancy(occupancy1)
  );

  holy_pipe_stage #(.WIDTH(32), .SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .flush(flush0), .occupancy(occupancy0)
  );

  // Scoreboard: checks status against the FIFO model, pops on output
  // handshakes, then applies flush or pushes accepted inputs.
  always @(negedge clk) begin
    logic [31:0] exp;
    logic        exp_rdy;
    if (rst) begin
      q1.delete();
      q0.delete();
      fresh = 1'b1;
      hold1_prev = 1'b0;
    end else begin
      // ---- SKID=1 instance ----
      checks++;
      if (occupancy1 !== 2'(q1.size())) begin
        errors++; $display("FAIL sb1_occupancy: got %0d expected %0d", occupancy1, q1.size());
      end
      checks++;
      if (out_valid1 !== (q1.size() != 0)) begin
        errors++; $display("FAIL sb1_out_valid: got %b expected %b", out_valid1, q1.size() != 0);
      end
      exp_rdy = !fresh && (q1.size() < 2);
      checks++;
      if (in_ready1 !== exp_rdy) begin
        errors++; $display("FAIL sb1_in_ready: got %b expected %b", in_ready1, exp_rdy);
      end
      if (!out_valid1) begin
        checks++;
        if (out_data1 !== BUBBLE1) begin
          errors++; $display("FAIL sb1_bubble: got %h expected %h", out_data1, BUBBLE1);
        end
      end
      if (hold1_prev) begin
        checks++;
        if (out_data1 !== data1_prev) begin
          errors++; $display("FAIL sb1_stable: got %h expected %h", out_data1, data1_prev);
        end
      end
      hold1_prev = out_valid1 && !out_ready1 && !flush1;
      data1_prev = out_data1;
      if (out_valid1 && out_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL sb1_unexpected_out: got %h expected none", out_data1);
        end else begin
          exp = q1.pop_front();
          if (out_data1 !== exp) begin
            errors++; $display("FAIL sb1_order: got %h expected %h", out_data1, exp);
          end
        end
      end
      if (flush1) q1.delete();
      else if (in_valid1 && in_ready1) q1.push_back(in_data1);

      // ---- SKID=0 instance ----
      checks++;
      if (occupancy0 !== 2'(q0.size())) begin
        errors++; $display("FAIL sb0_occupancy: got %0d expected %0d", occupancy0, q0.size());
      end
      checks++;
      if (out_valid0 !== (q0.size() != 0)) begin
        errors++; $display("FAIL sb0_out_valid: got %b expected %b", out_valid0, q0.size() != 0);
      end
      exp_rdy = !fresh && ((q0.size() == 0) || out_ready0);
      checks++;
      if (in_ready0 !== exp_rdy) begin
        errors++; $display("FAIL sb0_in_ready: got %b expected %b", in_ready0, exp_rdy);
      end
      if (!out_valid0) begin
        checks++;
        if (out_data0 !== BUBBLE0) begin
          errors++; $display("FAIL sb0_bubble: got %h expected %h", out_data0, BUBBLE0);
        end
      end
      if (out_valid0 && out_ready0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL sb0_unexpected_out: got %h expected none", out_data0);
        end else begin
          exp = q0.pop_front();
          if (out_data0 !== exp) begin
            errors++; $display("FAIL sb0_order: got %h expected %h", out_data0, exp);
          end
        end
      end
      if (flush0) q0.delete();
      else if (in_valid0 && in_ready0) q0.push_back(in_data0);

      fresh = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0 || in_ready1 !== 1'b0 || out_data1 !== BUBBLE1) begin
      errors++; $display("FAIL reset_state1: got v=%b occ=%0d rdy=%b d=%h expected 0 0 0 %h",
                         out_valid1, occupancy1, in_ready1, out_data1, BUBBLE1);
    end
    checks++;
    if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0 || in_ready0 !== 1'b0 || out_data0 !== BUBBLE0) begin
      errors++; $display("FAIL reset_state0: got v=%b occ=%0d rdy=%b d=%h expected 0 0 0 0",
                         out_valid0, occupancy0, in_ready0, out_data0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b/%b expected 1/1", in_ready1, in_ready0);
    end
  endtask

  task automatic test_throughput();
    out_ready1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid1 = 1'b1;
      in_data1  = 32'(i);
      checks++;
      if (in_ready1 !== 1'b1) begin
        errors++; $display("FAIL tput_ready[%0d]: got %b expected 1", i, in_ready1);
      end
      tick();
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== 32'(i)) begin
        errors++; $display("FAIL tput_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid1, out_data1, 32'(i));
      end
    end
    in_valid1 = 1'b0;
    tick();
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++; $display("FAIL tput_drain: got %b expected 0", out_valid1);
    end
  endtask

  task automatic test_backpressure();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 32'hA;
    tick();
    in_data1   = 32'hB;
    tick();
    in_data1   = 32'hE;
    checks++;
    if (occupancy1 !== 2'd2 || in_ready1 !== 1'b0 || out_data1 !== 32'hA) begin
      errors++; $display("FAIL bp_skidded: got occ=%0d rdy=%b d=%h expected 2 0 a", occupancy1, in_ready1, out_data1);
    end
    repeat (2) tick();
    checks++;
    if (occupancy1 !== 2'd2 || out_data1 !== 32'hA) begin
      errors++; $display("FAIL bp_hold: got occ=%0d d=%h expected 2 a", occupancy1, out_data1);
    end
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    tick();
    checks++;
    if (out_data1 !== 32'hB || occupancy1 !== 2'd1 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL bp_second: got d=%h occ=%0d rdy=%b expected b 1 1", out_data1, occupancy1, in_ready1);
    end
    tick();
    checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== BUBBLE1) begin
      errors++; $display("FAIL bp_empty: got v=%b d=%h expected 0 %h", out_valid1, out_data1, BUBBLE1);
    end
  endtask

  task automatic test_flush();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 32'hA;
    tick();
    in_data1   = 32'hB;
    tick();
    flush1     = 1'b1;
    in_data1   = 32'hC;
    tick();
    flush1     = 1'b0;
    in_valid1  = 1'b0;
    checks++;
    if (occupancy1 !== 2'd0 || out_valid1 !== 1'b0 || out_data1 !== BUBBLE1) begin
      errors++; $display("FAIL flush_state: got occ=%0d v=%b d=%h expected 0 0 %h", occupancy1, out_valid1, out_data1, BUBBLE1);
    end
    out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid1 !== 1'b0) begin
        errors++; $display("FAIL flush_no_c[%0d]: got v=%b d=%h expected v=0", i, out_valid1, out_data1);
      end
    end
  endtask

  task automatic test_skid0();
    logic       acc;
    logic [2:0] pat;
    pat       = 3'b101;
    in_valid0 = 1'b1;
    in_data0  = 32'h100;
    out_ready0 = 1'b1;
    tick();
    in_data0  = 32'h101;
    for (int i = 0; i < 12; i++) begin
      out_ready0 = pat[i % 3];
      #1;
      if (out_valid0) begin
        checks++;
        if (in_ready0 !== out_ready0) begin
          errors++; $display("FAIL skid0_mirror[%0d]: got %b expected %b", i, in_ready0, out_ready0);
        end
      end
      acc = in_ready0;
      tick();
      if (acc) in_data0 = in_data0 + 32'd1;
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid0 !== 1'b0 || q0.size() != 0) begin
      errors++; $display("FAIL skid0_drain: got v=%b pending=%0d expected 0 0", out_valid0, q0.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 32'h55;
    tick();
    in_valid1  = 1'b0;
    checks++;
    if (occupancy1 !== 2'd1) begin
      errors++; $display("FAIL rmid_loaded: got %0d expected 1", occupancy1);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0 || in_ready1 !== 1'b0 || out_data1 !== BUBBLE1) begin
      errors++; $display("FAIL rmid_async: got v=%b occ=%0d rdy=%b d=%h expected 0 0 0 %h",
                         out_valid1, occupancy1, in_ready1, out_data1, BUBBLE1);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL rmid_release: got rdy=%b v=%b expected 1 0", in_ready1, out_valid1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      in_valid1  = 1'($urandom_range(0, 1));
      out_ready1 = 1'($urandom_range(0, 1));
      flush1     = ($urandom_range(0, 15) == 0);
      in_data1   = $urandom();
      in_valid0  = 1'($urandom_range(0, 1));
      out_ready0 = 1'($urandom_range(0, 1));
      flush0     = ($urandom_range(0, 15) == 0);
      in_data0   = $urandom();
      tick();
    end
    in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b1;
    in_valid0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b1;
    repeat (3) tick();
    checks++;
    if (q1.size() != 0 || q0.size() != 0 || out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
      errors++; $display("FAIL random_drain: got pending=%0d/%0d expected 0/0", q1.size(), q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_flush();
    test_skid0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
